// File: rtl/pupil_pkg.sv
// Shared types and constants for the pupil-search scan controller.
package pupil_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitFrm,
    StScan,
    StDrain,
    StWaitDet,
    StDone
  } scan_state_e;

  localparam int unsigned IMG_W_DEF = 112;
  localparam int unsigned IMG_H_DEF = 112;
  localparam int unsigned PIX_W_DEF = 8;
  localparam int unsigned FRAME_PIX = IMG_W_DEF * IMG_H_DEF;
  localparam int unsigned LOC_W     = 9;

endpackage

// File: rtl/pix_skid_buf.sv
// One-entry valid/ready skid stage: an output register backed by a single skid register.
module pix_skid_buf
  import pupil_pkg::*;
#(
  parameter int unsigned WIDTH = PIX_W_DEF + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             skid_valid
);

  logic             out_valid_q;
  logic             skid_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [WIDTH-1:0] skid_data_q;

  // The producer never presents data while both registers are full and stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_data_q   <= '0;
      skid_data_q  <= '0;
    end else if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        out_valid_q  <= 1'b1;
        out_data_q   <= skid_data_q;
        skid_valid_q <= in_valid;
        if (in_valid) begin
          skid_data_q <= in_data;
        end
      end else begin
        out_valid_q <= in_valid;
        if (in_valid) begin
          out_data_q <= in_data;
        end
      end
    end else if (in_valid) begin
      skid_valid_q <= 1'b1;
      skid_data_q  <= in_data;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign skid_valid = skid_valid_q;

endmodule

// File: rtl/pupil_scan_ctrl.sv
// Pupil-search pass sequencer: waits for a frame, streams it to the detector with
// backpressure, then captures the detector result and raises a completion interrupt.
module pupil_scan_ctrl
  import pupil_pkg::*;
#(
  parameter int unsigned IMG_W       = IMG_W_DEF,
  parameter int unsigned IMG_H       = IMG_H_DEF,
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned PIX_W       = PIX_W_DEF,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic              PCLK,
  input  logic              PRESERN,
  input  logic              start,
  input  logic              frame_ready,
  output logic              buf_rd_en,
  output logic [ADDR_W-1:0] buf_addr,
  input  logic [PIX_W-1:0]  buf_rdata,
  output logic              pix_valid,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_last,
  input  logic              det_ready,
  input  logic              det_done,
  input  logic [LOC_W-1:0]  det_location,
  output logic [LOC_W-1:0]  pupil_location,
  output logic              busy,
  output logic              irq,
  output logic              err_overrun,
  output logic              err_timeout
);

  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC);

  scan_state_e       state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  logic [TMR_W-1:0]  tmr_q;
  logic [LOC_W-1:0]  loc_q;
  logic              rvalid_q;
  logic              rlast_q;
  logic              busy_q;
  logic              irq_q;
  logic              ovr_q;
  logic              tmo_q;

  logic              skid_valid;
  logic              pop;
  logic              frame_end;
  logic [1:0]        occ;
  logic [PIX_W:0]    out_word;

  assign pop       = pix_valid & det_ready;
  assign frame_end = (row_q == ROW_W'(IMG_H - 1)) && (col_q == COL_W'(IMG_W - 1));

  // Pixels held after this cycle, counting the read landing now; a new read is only
  // issued if it could still be parked should the detector stall next cycle.
  always_comb begin
    occ       = 2'(pix_valid) + 2'(skid_valid) + 2'(rvalid_q) - 2'(pop);
    buf_rd_en = (state_q == StScan) && (occ <= 2'd1);
  end

  always_ff @(posedge PCLK) begin
    if (!PRESERN) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      col_q    <= '0;
      row_q    <= '0;
      tmr_q    <= '0;
      loc_q    <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      busy_q   <= 1'b0;
      irq_q    <= 1'b0;
      ovr_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      rvalid_q <= buf_rd_en;
      rlast_q  <= buf_rd_en & frame_end;
      irq_q    <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StWaitFrm;
            busy_q  <= 1'b1;
            ovr_q   <= 1'b0;
            tmo_q   <= 1'b0;
          end
        end
        StWaitFrm: begin
          if (frame_ready) begin
            state_q <= StScan;
            addr_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
          end
        end
        StScan: begin
          if (frame_ready) begin
            ovr_q <= 1'b1;
          end
          if (buf_rd_en) begin
            addr_q <= addr_q + ADDR_W'(1);
            if (col_q == COL_W'(IMG_W - 1)) begin
              col_q <= '0;
              row_q <= row_q + ROW_W'(1);
            end else begin
              col_q <= col_q + COL_W'(1);
            end
            if (frame_end) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if (frame_ready) begin
            ovr_q <= 1'b1;
          end
          if (pop && pix_last) begin
            state_q <= StWaitDet;
            tmr_q   <= '0;
          end
        end
        StWaitDet: begin
          if (det_done) begin
            loc_q   <= det_location;
            state_q <= StDone;
            irq_q   <= 1'b1;
            busy_q  <= 1'b0;
          end else if (tmr_q == TMR_W'(TIMEOUT_CYC - 1)) begin
            tmo_q   <= 1'b1;
            state_q <= StDone;
            irq_q   <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  pix_skid_buf #(
    .WIDTH (PIX_W + 1)
  ) u_skid (
    .clk        (PCLK),
    .rst_n      (PRESERN),
    .in_valid   (rvalid_q),
    .in_data    ({rlast_q, buf_rdata}),
    .out_ready  (det_ready),
    .out_valid  (pix_valid),
    .out_data   (out_word),
    .skid_valid (skid_valid)
  );

  assign pix_data       = out_word[PIX_W-1:0];
  assign pix_last       = pix_valid & out_word[PIX_W];
  assign buf_addr       = addr_q;
  assign pupil_location = loc_q;
  assign busy           = busy_q;
  assign irq            = irq_q;
  assign err_overrun    = ovr_q;
  assign err_timeout    = tmo_q;

endmodule
